// File: rtl/banco_registros_param.sv
// Register bank: byte-splittable general registers plus auto-stepping pointers.
// Define BANCO_SHADOW_EN to add a swappable shadow copy of the general set.
module banco_registros_param #(
    parameter int WIDTH = 16,
    parameter int NGEN  = 4,
    parameter int NPTR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd,
    input  logic             wr,
    input  logic [4:0]       sel,
    input  logic [WIDTH-1:0] din,
    input  logic             step,
    input  logic [2:0]       psel,
    input  logic             dir,
`ifdef BANCO_SHADOW_EN
    input  logic             swap,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             err
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] gen     [NGEN];
    logic [WIDTH-1:0] gen_w   [NGEN];
    logic [WIDTH-1:0] ptr     [NPTR];
    logic [WIDTH-1:0] ptr_nxt [NPTR];
`ifdef BANCO_SHADOW_EN
    logic [WIDTH-1:0] gen_sh  [NGEN];
`endif

    logic [2:0]       idx;
    logic             is_lo;
    logic             is_hi;
    logic             is_full;
    logic             is_ptr;
    logic             mapped;
    logic             wr_ok;
    logic             rd_pre;
    logic [WIDTH-1:0] rgen;
    logic [WIDTH-1:0] rptr;
    logic [WIDTH-1:0] rdata;
    logic             dv_q;

    assign idx     = sel[2:0];
    assign is_lo   = (sel[4:3] == 2'd0);
    assign is_hi   = (sel[4:3] == 2'd1);
    assign is_full = (sel[4:3] == 2'd2);
    assign is_ptr  = (sel[4:3] == 2'd3);

    always_comb begin
        if (is_ptr) mapped = (32'(idx) < 32'(NPTR));
        else        mapped = (32'(idx) < 32'(NGEN));
    end

    assign wr_ok = wr & mapped;

`ifdef BANCO_SHADOW_EN
    assign rd_pre = swap;
`else
    assign rd_pre = 1'b0;
`endif

    // A write in a swap cycle merges into the set that becomes active.
    always_comb begin
        for (int i = 0; i < NGEN; i++) begin
            gen_w[i] = gen[i];
`ifdef BANCO_SHADOW_EN
            if (swap) gen_w[i] = gen_sh[i];
`endif
            if (wr_ok && !is_ptr && idx == 3'(i)) begin
                unique case (1'b1)
                    is_lo:   gen_w[i][H-1:0]     = din[H-1:0];
                    is_hi:   gen_w[i][WIDTH-1:H] = din[H-1:0];
                    is_full: gen_w[i]            = din;
                    default: ;
                endcase
            end
        end
    end

    // A pointer write in the same cycle as a step suppresses the step.
    always_comb begin
        for (int j = 0; j < NPTR; j++) begin
            ptr_nxt[j] = ptr[j];
            if (wr_ok && is_ptr && idx == 3'(j)) begin
                ptr_nxt[j] = din;
            end else if (step && psel == 3'(j)) begin
                if (dir) ptr_nxt[j] = ptr[j] - WIDTH'(2);
                else     ptr_nxt[j] = ptr[j] + WIDTH'(2);
            end
        end
    end

    always_comb begin
        rgen = '0;
        rptr = '0;
        for (int i = 0; i < NGEN; i++) begin
            if (idx == 3'(i)) rgen = rd_pre ? gen[i] : gen_w[i];
        end
        for (int j = 0; j < NPTR; j++) begin
            if (idx == 3'(j)) rptr = ptr_nxt[j];
        end
    end

    always_comb begin
        rdata = '0;
        if (mapped) begin
            unique case (1'b1)
                is_lo:   rdata = {{(WIDTH-H){1'b0}}, rgen[H-1:0]};
                is_hi:   rdata = {{(WIDTH-H){1'b0}}, rgen[WIDTH-1:H]};
                is_full: rdata = rgen;
                is_ptr:  rdata = rptr;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NGEN; i++) begin
                gen[i] <= '0;
`ifdef BANCO_SHADOW_EN
                gen_sh[i] <= '0;
`endif
            end
            for (int j = 0; j < NPTR; j++) begin
                ptr[j] <= '0;
            end
            dout <= '0;
            dv_q <= 1'b0;
            err  <= 1'b0;
        end else begin
            for (int i = 0; i < NGEN; i++) begin
                gen[i] <= gen_w[i];
`ifdef BANCO_SHADOW_EN
                if (swap) gen_sh[i] <= gen[i];
`endif
            end
            for (int j = 0; j < NPTR; j++) begin
                ptr[j] <= ptr_nxt[j];
            end
            if (rd) dout <= rdata;
            dv_q <= rd;
            err  <= (rd | wr) & ~mapped;
        end
    end

    // Reset in the cycle a read result would appear cancels that result.
    assign dvalid = dv_q & ~rst;

endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench for banco_registros_param (default parameters).
// Shadow-set sequences run only when BANCO_SHADOW_EN is defined.
module tb_banco_registros_param;

    localparam int NG = 4;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [4:0]  sel;
    logic [15:0] din;
    logic        step;
    logic [2:0]  psel;
    logic        dir;
`ifdef BANCO_SHADOW_EN
    logic        swap;
`endif
    logic [15:0] dout;
    logic        dvalid;
    logic        err;

    banco_registros_param #(
        .WIDTH(16),
        .NGEN (NG),
        .NPTR (NP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rd    (rd),
        .wr    (wr),
        .sel   (sel),
        .din   (din),
        .step  (step),
        .psel  (psel),
        .dir   (dir),
`ifdef BANCO_SHADOW_EN
        .swap  (swap),
`endif
        .dout  (dout),
        .dvalid(dvalid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sbq[$];
    logic        started = 1'b0;
    logic        p_rd  = 1'b0;
    logic        p_rst = 1'b1;
    logic        p_err = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit mapped(input logic [4:0] s);
        if (s[4:3] == 2'd3) return int'(s[2:0]) < NP;
        return int'(s[2:0]) < NG;
    endfunction

    // Drive one cycle; at mid-cycle check what the previous cycle produced.
    task automatic op(input logic r, input logic w, input logic [4:0] s,
                      input logic [15:0] d, input logic [15:0] e,
                      input logic st, input logic [2:0] ps,
                      input logic dr, input logic rs, input logic sw);
        logic [15:0] x;
        rd = r; wr = w; sel = s; din = d;
        step = st; psel = ps; dir = dr; rst = rs;
`ifdef BANCO_SHADOW_EN
        swap = sw;
`else
        if (sw) $display("note: swap ignored without shadow set");
`endif
        @(negedge clk);
        if (started) begin
            chk("dvalid", 16'(dvalid), 16'(p_rd && !p_rst && !rs));
            chk("err", 16'(err), 16'(p_err && !p_rst));
            if (p_rd && !p_rst && sbq.size() > 0) begin
                x = sbq.pop_front();
                if (!rs) chk("dout", dout, x);
            end
        end
        started = 1'b1;
        if (r && !rs) sbq.push_back(e);
        p_rd  = r;
        p_rst = rs;
        p_err = (r | w) && !mapped(s) && !rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic wrx(input logic [4:0] s, input logic [15:0] d);
        op(0, 1, s, d, 16'h0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic rdx(input logic [4:0] s, input logic [15:0] e);
        op(1, 0, s, 16'h0, e, 0, 3'd0, 0, 0, 0);
    endtask

    initial begin
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 1, 0);
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 1, 0);
        idle();
        chk("rst_dout", dout, 16'h0000);

        // byte views of a full write
        wrx(5'd16, 16'h1234);
        rdx(5'd0, 16'h0034);
        rdx(5'd8, 16'h0012);
        rdx(5'd16, 16'h1234);

        // half write keeps other half; write-through
        wrx(5'd17, 16'h5566);
        wrx(5'd9, 16'h00AB);
        rdx(5'd17, 16'hAB66);
        op(1, 1, 5'd17, 16'h7777, 16'h7777, 0, 3'd0, 0, 0, 0);
        rdx(5'd1, 16'h0077);
        op(1, 1, 5'd1, 16'h0099, 16'h0099, 0, 3'd0, 0, 0, 0);
        rdx(5'd17, 16'h7799);

        // pointer stepping and wrap
        wrx(5'd24, 16'hFFFE);
        op(1, 0, 5'd24, 16'h0, 16'h0000, 1, 3'd0, 0, 0, 0);
        op(0, 0, 5'd0, 16'h0, 16'h0, 1, 3'd0, 1, 0, 0);
        op(1, 0, 5'd24, 16'h0, 16'hFFFC, 1, 3'd0, 1, 0, 0);
        op(1, 1, 5'd24, 16'h0100, 16'h0100, 1, 3'd0, 1, 0, 0);
        rdx(5'd24, 16'h0100);
        op(0, 0, 5'd0, 16'h0, 16'h0, 1, 3'd5, 0, 0, 0);
        rdx(5'd24, 16'h0100);
        rdx(5'd25, 16'h0000);

        // unmapped selects
        rdx(5'd5, 16'h0000);
        wrx(5'd21, 16'hFFFF);
        rdx(5'd12, 16'h0000);
        rdx(5'd29, 16'h0000);
        rdx(5'd16, 16'h1234);
        rdx(5'd17, 16'h7799);
        rdx(5'd18, 16'h0000);
        rdx(5'd19, 16'h0000);

        // back-to-back reads
        for (int i = 0; i < NP; i++) begin
            wrx(5'(24 + i), 16'(16'h0F0F + 16'h1000 * i));
        end
        for (int i = 0; i < NP; i++) begin
            rdx(5'(24 + i), 16'(16'h0F0F + 16'h1000 * i));
        end
        idle();

        // reset cancels an in-flight read and clears everything
        rdx(5'd16, 16'h1234);
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 1, 0);
        idle();
        for (int i = 0; i < NG; i++) rdx(5'(16 + i), 16'h0000);
        for (int i = 0; i < NP; i++) rdx(5'(24 + i), 16'h0000);
        idle();

`ifdef BANCO_SHADOW_EN
        wrx(5'd16, 16'h1111);
        wrx(5'd26, 16'h3333);
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 1);
        wrx(5'd16, 16'h2222);
        op(1, 0, 5'd16, 16'h0, 16'h2222, 0, 3'd0, 0, 0, 1);
        rdx(5'd16, 16'h1111);
        rdx(5'd26, 16'h3333);
        op(0, 1, 5'd16, 16'h4444, 16'h0, 0, 3'd0, 0, 0, 1);
        rdx(5'd16, 16'h4444);
        op(0, 0, 5'd0, 16'h0, 16'h0, 0, 3'd0, 0, 0, 1);
        rdx(5'd16, 16'h1111);
        rdx(5'd26, 16'h3333);
        idle();
`endif

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
